// File: rtl/i2s_sample_fifo.sv
// Sample FIFO between the PS bus writer and the I2S transmitter.
// Pops are paced by DATA_CLK rising edges; sticky flags report underrun and overflow.
module i2s_sample_fifo #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          DATA_CLK,
  input  logic          mute,
  input  logic          clr_flags,
  output logic [DW-1:0] data_output,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          underrun,
  output logic          overflow
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LVL_ONE   = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic [DW-1:0] data_output_r;
  logic          underrun_r;
  logic          overflow_r;
  logic          s1_r;
  logic          s2_r;
  logic          s3_r;
  logic          pop_req_s;
  logic          wr_ok_s;
  logic          rd_ok_s;
  logic          under_set_s;
  logic          over_set_s;

  // DATA_CLK synchronizer plus history flop for rising-edge detection
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= DATA_CLK;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Push/pop qualification and next occupancy; a push is judged against the current full state only
  always_comb begin
    pop_req_s   = s2_r & ~s3_r;
    wr_ok_s     = wr_en & ~full_r;
    rd_ok_s     = pop_req_s & ~mute & ~empty_r;
    under_set_s = pop_req_s & ~mute & empty_r;
    over_set_s  = wr_en & full_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Sample storage; contents are deliberately left unreset
  always_ff @(posedge CLK) begin
    if (RST_n && wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, output sample and sticky flags
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      level_r       <= '0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      data_output_r <= '0;
      underrun_r    <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == DEPTH_LVL);
      empty_r <= (level_nxt_s == '0);
      if (rd_ok_s) begin
        data_output_r <= mem_r[rd_ptr_r];
      end else if (pop_req_s) begin
        data_output_r <= '0;
      end
      // a set condition in the same cycle overrides clr_flags
      underrun_r <= under_set_s | (underrun_r & ~clr_flags);
      overflow_r <= over_set_s | (overflow_r & ~clr_flags);
    end
  end

  assign data_output = data_output_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign level       = level_r;
  assign underrun    = underrun_r;
  assign overflow    = overflow_r;

  i2s_sample_fifo_chk #(.AW(AW)) u_chk (
    .CLK   (CLK),
    .RST_n (RST_n),
    .full  (full_r),
    .empty (empty_r),
    .level (level_r)
  );

endmodule

// Consistency properties on the FIFO status outputs.
module i2s_sample_fifo_chk #(
  parameter int AW = 4
) (
  input logic        CLK,
  input logic        RST_n,
  input logic        full,
  input logic        empty,
  input logic [AW:0] level
);

  localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};

  a_not_full_and_empty: assert property (@(posedge CLK) disable iff (!RST_n) !(full && empty));
  a_level_bound:        assert property (@(posedge CLK) disable iff (!RST_n) level <= DEPTH_LVL);
  a_empty_matches:      assert property (@(posedge CLK) disable iff (!RST_n) empty == (level == '0));
  a_full_matches:       assert property (@(posedge CLK) disable iff (!RST_n) full == (level == DEPTH_LVL));

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: vector table plus scoreboarded corner sequences.
module tb_i2s_sample_fifo;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        DATA_CLK;
  logic        mute;
  logic        clr_flags;
  logic [15:0] data_output;
  logic        full;
  logic        empty;
  logic [4:0]  level;
  logic        underrun;
  logic        overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] sb_q [$];
  logic [15:0] exp_dout;
  logic        model_under;
  logic        model_over;

  typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_CLR} op_e;
  typedef struct {
    op_e         op;
    logic [15:0] din;
    logic        mte;
    logic [4:0]  lvl;
    logic        emp;
    logic        ful;
    logic        und;
    logic        ovf;
  } vec_t;
  vec_t vecs [13];

  i2s_sample_fifo #(.DW(16), .AW(4)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .DATA_CLK    (DATA_CLK),
    .mute        (mute),
    .clr_flags   (clr_flags),
    .data_output (data_output),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick(1);
    wr_en = 1'b0;
    if (sb_q.size() < 16) sb_q.push_back(d);
    else model_over = 1'b1;
  endtask

  task automatic do_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags   = 1'b0;
    model_under = 1'b0;
    model_over  = 1'b0;
  endtask

  // One DATA_CLK pulse; w/wd/c are driven in the pop_req cycle so they coincide with the pop.
  task automatic do_pop(input logic m, input logic w, input logic [15:0] wd, input logic c);
    logic push_ok;
    mute     = m;
    DATA_CLK = 1'b1;
    tick(2);
    chk("pop_hold_before_third_edge", 32'(data_output), 32'(exp_dout));
    wr_en     = w;
    wr_data   = wd;
    clr_flags = c;
    push_ok   = w && (sb_q.size() < 16);
    tick(1);
    wr_en     = 1'b0;
    clr_flags = 1'b0;
    mute      = 1'b0;
    if (c) begin
      model_under = 1'b0;
      model_over  = 1'b0;
    end
    if (m) exp_dout = 16'h0000;
    else if (sb_q.size() == 0) begin
      exp_dout    = 16'h0000;
      model_under = 1'b1;
    end else exp_dout = sb_q.pop_front();
    if (push_ok) sb_q.push_back(wd);
    else if (w) model_over = 1'b1;
    chk("pop_data", 32'(data_output), 32'(exp_dout));
    chk("pop_level", 32'(level), 32'(sb_q.size()));
    chk("pop_underrun", 32'(underrun), 32'(model_under));
    chk("pop_overflow", 32'(overflow), 32'(model_over));
    DATA_CLK = 1'b0;
    tick(3);
  endtask

  initial begin
    vecs[0]  = '{OP_PUSH, 16'h1111, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{OP_PUSH, 16'h2222, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_PUSH, 16'h3333, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_POP,  16'h0000, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_POP,  16'h0000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{OP_POP,  16'h0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_POP,  16'h0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{OP_CLR,  16'h0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_PUSH, 16'hA5A5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_PUSH, 16'h5A5A, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_POP,  16'h0000, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{OP_POP,  16'h0000, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{OP_POP,  16'h0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    RST_n = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; DATA_CLK = 1'b0;
    mute = 1'b0; clr_flags = 1'b0;
    exp_dout = 16'h0000; model_under = 1'b0; model_over = 1'b0;
    tick(2);
    chk("rst_data", 32'(data_output), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    RST_n = 1'b1;
    tick(1);

    // 56-cycle DATA_CLK pulse after reset: exactly one pop, as an underrun
    DATA_CLK = 1'b1;
    tick(3);
    chk("long_pulse_data", 32'(data_output), 32'h0);
    chk("long_pulse_underrun", 32'(underrun), 32'h1);
    chk("long_pulse_level", 32'(level), 32'h0);
    tick(5);
    do_clr();
    tick(47);
    chk("long_pulse_single_pop", 32'(underrun), 32'h0);
    DATA_CLK = 1'b0;
    tick(4);

    for (int i = 0; i < 13; i++) begin
      case (vecs[i].op)
        OP_PUSH: do_push(vecs[i].din);
        OP_POP:  do_pop(vecs[i].mte, 1'b0, 16'h0000, 1'b0);
        default: do_clr();
      endcase
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].ful));
      chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].und));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // Fill past capacity across pointer wrap, then drain in order
    for (int i = 0; i < 17; i++) do_push(16'(i));
    chk("full_flag", 32'(full), 32'h1);
    chk("full_level", 32'(level), 32'd16);
    chk("full_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) do_pop(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("drain_empty", 32'(empty), 32'h1);
    do_clr();

    // Push coinciding with pop at full, then at level 5
    for (int i = 0; i < 16; i++) do_push(16'h0100 + 16'(i));
    do_pop(1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk("full_pop_push_level", 32'(level), 32'd15);
    chk("full_pop_push_overflow", 32'(overflow), 32'h1);
    for (int i = 0; i < 10; i++) do_pop(1'b0, 1'b0, 16'h0000, 1'b0);
    do_pop(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("mid_pop_push_level", 32'(level), 32'd5);
    for (int i = 0; i < 5; i++) do_pop(1'b0, 1'b0, 16'h0000, 1'b0);
    do_clr();

    // Mute at level 2, then push + underrun + clr in one cycle
    do_push(16'h0A0A);
    do_push(16'h0B0B);
    do_pop(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("mute_level", 32'(level), 32'd2);
    chk("mute_data", 32'(data_output), 32'h0);
    do_pop(1'b0, 1'b0, 16'h0000, 1'b0);
    do_pop(1'b0, 1'b0, 16'h0000, 1'b0);
    do_pop(1'b0, 1'b1, 16'h7777, 1'b1);
    chk("set_wins_underrun", 32'(underrun), 32'h1);
    chk("empty_push_level", 32'(level), 32'd1);
    do_pop(1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset mid-stream discards stored samples
    for (int i = 0; i < 4; i++) do_push(16'hC000 + 16'(i));
    RST_n = 1'b0;
    tick(1);
    RST_n = 1'b1;
    sb_q.delete();
    exp_dout = 16'h0000; model_under = 1'b0; model_over = 1'b0;
    chk("midrst_level", 32'(level), 32'h0);
    chk("midrst_empty", 32'(empty), 32'h1);
    chk("midrst_data", 32'(data_output), 32'h0);
    chk("midrst_underrun", 32'(underrun), 32'h0);
    tick(1);
    do_pop(1'b0, 1'b0, 16'h0000, 1'b0);

    // DATA_CLK high across reset release: one spurious underrun only
    DATA_CLK = 1'b1;
    RST_n = 1'b0;
    tick(2);
    RST_n = 1'b1;
    tick(5);
    chk("rel_high_underrun", 32'(underrun), 32'h1);
    chk("rel_high_level", 32'(level), 32'h0);
    exp_dout = 16'h0000; model_under = 1'b1; model_over = 1'b0;
    do_push(16'h4242);
    tick(5);
    chk("rel_high_no_second_pop", 32'(level), 32'h1);
    DATA_CLK = 1'b0;
    tick(3);
    do_pop(1'b0, 1'b0, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
